// File: rtl/flush_sequencer_pkg.sv
// Shared state encoding, parameter defaults and sizing helper for the flush sequencer.
package flush_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_REDIRECT = 2'd3
    } seq_state_e;

    localparam int unsigned FLUSH_CYCLES_DEFAULT  = 2;
    localparam int unsigned DRAIN_TIMEOUT_DEFAULT = 64;
    localparam int unsigned PC_WIDTH_DEFAULT      = 32;
    localparam int unsigned BHT_ID_WIDTH_DEFAULT  = 8;
    localparam int unsigned FLUSH_COUNT_W         = 16;
    localparam int unsigned DRAIN_CYCLES_W        = 24;

    // Timer width able to hold the full parameter value without wrapping.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/flush_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module flush_sequencer_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/flush_sequencer.sv
// Commit-time redirect sequencer: drain committed stores, flush speculative units, redirect fetch.
// Optional FLUSH_STATS_EN adds completed-sequence and total-drain-cycle counters.
module flush_sequencer
    import flush_sequencer_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES  = FLUSH_CYCLES_DEFAULT,
    parameter int unsigned DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEFAULT,
    parameter int unsigned PC_WIDTH      = PC_WIDTH_DEFAULT,
    parameter int unsigned BHT_ID_WIDTH  = BHT_ID_WIDTH_DEFAULT
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    redirect_in,
    input  logic [PC_WIDTH-1:0]     next_pc_in,
    input  logic                    br_commit_in,
    input  logic [PC_WIDTH-1:0]     br_pc_in,
    input  logic                    br_taken_in,
    input  logic                    ls_committed_pending_in,
    output logic                    commit_stall_out,
    output logic                    flush_out,
    output logic                    fetch_redirect_out,
    output logic [PC_WIDTH-1:0]     fetch_pc_out,
    output logic                    bp_valid_out,
    output logic [BHT_ID_WIDTH-1:0] bp_index_out,
    output logic                    bp_taken_out,
    output logic                    drain_timeout_out
`ifdef FLUSH_STATS_EN
    ,
    output logic [FLUSH_COUNT_W-1:0]  flush_count_out,
    output logic [DRAIN_CYCLES_W-1:0] drain_cycles_out
`endif
);

    localparam int unsigned FLUSH_CNT_W = cnt_width(FLUSH_CYCLES);
    localparam int unsigned DRAIN_CNT_W = cnt_width(DRAIN_TIMEOUT);

    seq_state_e              state_q, state_d;
    logic [PC_WIDTH-1:0]     target_q, target_d;
    logic [PC_WIDTH-1:0]     fetch_pc_q, fetch_pc_d;
    logic                    stall_q, stall_d;
    logic                    flush_q, flush_d;
    logic                    redir_q, redir_d;
    logic                    timeout_q, timeout_d;
    logic                    bp_valid_q, bp_taken_q;
    logic [BHT_ID_WIDTH-1:0] bp_index_q;
    logic [FLUSH_CNT_W-1:0]  flush_cnt;
    logic [DRAIN_CNT_W-1:0]  drain_cnt;
    logic                    in_drain, in_flush, flush_done, drain_expired;
    logic                    unused_pc_bits;

    assign in_drain      = (state_q == ST_DRAIN);
    assign in_flush      = (state_q == ST_FLUSH);
    assign flush_done    = (flush_cnt >= FLUSH_CNT_W'(FLUSH_CYCLES - 1));
    assign drain_expired = (drain_cnt >= DRAIN_CNT_W'(DRAIN_TIMEOUT - 1));
    assign unused_pc_bits = ^{br_pc_in[PC_WIDTH-1:BHT_ID_WIDTH+2], br_pc_in[1:0]};

    // Timers restart whenever their phase is not active, so each entry begins at zero.
    flush_sequencer_sat_counter #(.W(FLUSH_CNT_W)) u_flush_timer (
        .clk_i  (clk_in),
        .rst_ni (rst_in),
        .en_i   (rdy_in && in_flush),
        .clr_i  (rdy_in && !in_flush),
        .cnt_o  (flush_cnt)
    );

    flush_sequencer_sat_counter #(.W(DRAIN_CNT_W)) u_drain_timer (
        .clk_i  (clk_in),
        .rst_ni (rst_in),
        .en_i   (rdy_in && in_drain),
        .clr_i  (rdy_in && !in_drain),
        .cnt_o  (drain_cnt)
    );

    // Next state; with rdy_in low everything resolves to its current value.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        fetch_pc_d = fetch_pc_q;
        timeout_d  = timeout_q;
        if (rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    if (redirect_in) begin
                        target_d = next_pc_in;
                        state_d  = ls_committed_pending_in ? ST_DRAIN : ST_FLUSH;
                    end
                end
                ST_DRAIN: begin
                    if (drain_expired) begin
                        timeout_d = 1'b1;
                    end
                    if (!ls_committed_pending_in) begin
                        state_d = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (flush_done) begin
                        state_d = ST_REDIRECT;
                    end
                end
                ST_REDIRECT: state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
        stall_d = (state_d != ST_IDLE);
        flush_d = (state_d == ST_FLUSH);
        redir_d = (state_d == ST_REDIRECT);
        if (state_d == ST_REDIRECT) begin
            fetch_pc_d = target_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            target_q   <= '0;
            fetch_pc_q <= '0;
            stall_q    <= 1'b0;
            flush_q    <= 1'b0;
            redir_q    <= 1'b0;
            timeout_q  <= 1'b0;
            bp_valid_q <= 1'b0;
            bp_index_q <= '0;
            bp_taken_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            fetch_pc_q <= fetch_pc_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
            redir_q    <= redir_d;
            timeout_q  <= timeout_d;
            if (rdy_in) begin
                bp_valid_q <= br_commit_in;
                if (br_commit_in) begin
                    bp_index_q <= br_pc_in[BHT_ID_WIDTH+1:2];
                    bp_taken_q <= br_taken_in;
                end
            end
        end
    end

    // Pulses are masked while stalled; the held registers replay them once rdy_in returns.
    assign fetch_redirect_out = redir_q && rdy_in;
    assign bp_valid_out       = bp_valid_q && rdy_in;
    assign commit_stall_out   = stall_q;
    assign flush_out          = flush_q;
    assign fetch_pc_out       = fetch_pc_q;
    assign bp_index_out       = bp_index_q;
    assign bp_taken_out       = bp_taken_q;
    assign drain_timeout_out  = timeout_q;

`ifdef FLUSH_STATS_EN
    flush_sequencer_sat_counter #(.W(FLUSH_COUNT_W)) u_flush_count (
        .clk_i  (clk_in),
        .rst_ni (rst_in),
        .en_i   (rdy_in && (state_q == ST_REDIRECT)),
        .clr_i  (1'b0),
        .cnt_o  (flush_count_out)
    );

    flush_sequencer_sat_counter #(.W(DRAIN_CYCLES_W)) u_drain_cycles (
        .clk_i  (clk_in),
        .rst_ni (rst_in),
        .en_i   (rdy_in && in_drain),
        .clr_i  (1'b0),
        .cnt_o  (drain_cycles_out)
    );
`endif

endmodule

// File: tb/tb_flush_sequencer.sv
// Self-checking bench for flush_sequencer: directed scenarios plus randomized traffic vs a timeline model.
module tb_flush_sequencer;

    localparam int unsigned F  = 2;
    localparam int unsigned DT = 64;

    logic        clk_in, rst_in, rdy_in, redirect_in, br_commit_in, br_taken_in;
    logic        ls_committed_pending_in;
    logic [31:0] next_pc_in, br_pc_in;
    logic        commit_stall_out, flush_out, fetch_redirect_out, bp_valid_out;
    logic        bp_taken_out, drain_timeout_out;
    logic [31:0] fetch_pc_out;
    logic [7:0]  bp_index_out;
`ifdef FLUSH_STATS_EN
    logic [15:0] flush_count_out;
    logic [23:0] drain_cycles_out;
`endif

    flush_sequencer #(
        .FLUSH_CYCLES(F), .DRAIN_TIMEOUT(DT), .PC_WIDTH(32), .BHT_ID_WIDTH(8)
    ) dut (
        .clk_in                  (clk_in),
        .rst_in                  (rst_in),
        .rdy_in                  (rdy_in),
        .redirect_in             (redirect_in),
        .next_pc_in              (next_pc_in),
        .br_commit_in            (br_commit_in),
        .br_pc_in                (br_pc_in),
        .br_taken_in             (br_taken_in),
        .ls_committed_pending_in (ls_committed_pending_in),
        .commit_stall_out        (commit_stall_out),
        .flush_out               (flush_out),
        .fetch_redirect_out      (fetch_redirect_out),
        .fetch_pc_out            (fetch_pc_out),
        .bp_valid_out            (bp_valid_out),
        .bp_index_out            (bp_index_out),
        .bp_taken_out            (bp_taken_out),
        .drain_timeout_out       (drain_timeout_out)
`ifdef FLUSH_STATS_EN
        ,
        .flush_count_out         (flush_count_out),
        .drain_cycles_out        (drain_cycles_out)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    endtask

    // Timeline model: a sequence is cycles 1..d of drain, d+1..d+F of flush, d+F+1 redirect.
    bit          m_busy, m_draining, m_tmo, m_bpv, m_bptk;
    int unsigned m_k, m_d, m_seq, m_dcyc, exp_bp_total;
    logic [31:0] m_tgt, m_fpc;
    logic [7:0]  m_bpidx;
    int unsigned obs_flush, obs_redir, obs_bp, obs_drain;
    logic [7:0]  obs_last_idx;
    logic        obs_last_tk;
    int unsigned pend_left;

    task automatic model_reset();
        m_busy = 0; m_draining = 0; m_tmo = 0; m_bpv = 0; m_bptk = 0;
        m_k = 0; m_d = 0; m_tgt = '0; m_fpc = '0; m_bpidx = '0;
        m_seq = 0; m_dcyc = 0;
    endtask

    task automatic model_step();
        if (!rdy_in) return;
        m_bpv = br_commit_in;
        if (br_commit_in) begin
            m_bpidx = br_pc_in[9:2];
            m_bptk  = br_taken_in;
            exp_bp_total++;
        end
        if (!m_busy) begin
            if (redirect_in) begin
                m_busy = 1; m_k = 1; m_d = 0;
                m_draining = ls_committed_pending_in;
                m_tgt = next_pc_in;
            end
        end else if (m_draining) begin
            m_dcyc++;
            if (m_k >= DT) m_tmo = 1;
            if (!ls_committed_pending_in) begin
                m_draining = 0;
                m_d = m_k;
            end
            m_k++;
        end else if (m_k == m_d + F + 1) begin
            m_busy = 0;
            m_seq++;
        end else begin
            m_k++;
        end
        if (m_busy && !m_draining && m_k == m_d + F + 1) m_fpc = m_tgt;
    endtask

    task automatic compare();
        bit e_flush, e_redir;
        e_flush = m_busy && !m_draining && (m_k <= m_d + F);
        e_redir = m_busy && !m_draining && (m_k == m_d + F + 1);
        check("commit_stall", 64'(commit_stall_out), 64'(m_busy));
        check("flush", 64'(flush_out), 64'(e_flush));
        check("fetch_redirect", 64'(fetch_redirect_out), 64'(e_redir && rdy_in));
        check("fetch_pc", 64'(fetch_pc_out), 64'(m_fpc));
        check("bp_valid", 64'(bp_valid_out), 64'(m_bpv && rdy_in));
        if (m_bpv) begin
            check("bp_index", 64'(bp_index_out), 64'(m_bpidx));
            check("bp_taken", 64'(bp_taken_out), 64'(m_bptk));
        end
        check("drain_timeout", 64'(drain_timeout_out), 64'(m_tmo));
        if (flush_out) obs_flush++;
        if (fetch_redirect_out) obs_redir++;
        if (commit_stall_out && !flush_out && !fetch_redirect_out && rdy_in) obs_drain++;
        if (bp_valid_out) begin
            obs_bp++;
            obs_last_idx = bp_index_out;
            obs_last_tk  = bp_taken_out;
        end
    endtask

    task automatic cyc(input logic r, input logic rd, input logic [31:0] npc,
                       input logic brc, input logic [31:0] brpc, input logic brt,
                       input logic pend);
        @(negedge clk_in);
        rdy_in = r; redirect_in = rd; next_pc_in = npc;
        br_commit_in = brc; br_pc_in = brpc; br_taken_in = brt;
        ls_committed_pending_in = pend;
        #1;
        compare();
        @(posedge clk_in);
        model_step();
    endtask

    task automatic idle(input int unsigned n);
        for (int i = 0; i < n; i++) cyc(1, 0, 32'h0, 0, 32'h0, 0, 0);
    endtask

    task automatic rand_cycles(input int unsigned n, input bit allow_long);
        for (int i = 0; i < n; i++) begin
            logic r, rd, brc, brt;
            logic [31:0] npc, brpc;
            int unsigned sel;
            r = ($urandom_range(0, 99) < 85);
            rd = 0;
            npc = $urandom & 32'hFFFF_FFFC;
            if (!m_busy && $urandom_range(0, 5) == 0) begin
                rd = 1;
                sel = $urandom_range(0, 19);
                if (sel < 10) pend_left = 0;
                else if (sel < 19 || !allow_long) pend_left = $urandom_range(1, 8);
                else pend_left = $urandom_range(70, 75);
            end
            brc  = ($urandom_range(0, 2) == 0);
            brpc = $urandom;
            brt  = 1'($urandom_range(0, 1));
            cyc(r, rd, npc, brc, brpc, brt, pend_left != 0);
            if (r && pend_left != 0) pend_left--;
        end
    endtask

    int unsigned base_f, base_r, base_b, base_d;

    initial begin
        obs_flush = 0; obs_redir = 0; obs_bp = 0; obs_drain = 0; exp_bp_total = 0;
        obs_last_idx = '0; obs_last_tk = 0; pend_left = 0;
        rst_in = 0; rdy_in = 1; redirect_in = 0; next_pc_in = '0;
        br_commit_in = 0; br_pc_in = '0; br_taken_in = 0; ls_committed_pending_in = 0;
        model_reset();
        repeat (3) @(negedge clk_in);
        #1;
        compare();
        @(negedge clk_in);
        rst_in = 1;

        // Clean redirect to 0x1000: two flush cycles then a single redirect pulse.
        idle(9);
        base_f = obs_flush; base_r = obs_redir;
        cyc(1, 1, 32'h0000_1000, 0, 32'h0, 0, 0);
        idle(5);
        check("t1_flush_cycles", 64'(obs_flush - base_f), 64'(2));
        check("t1_redirect_pulses", 64'(obs_redir - base_r), 64'(1));
        check("t1_fetch_pc", 64'(fetch_pc_out), 64'h1000);

        // Five cycles of pending stores: five drain cycles, no timeout.
        base_d = obs_drain; base_f = obs_flush;
        cyc(1, 1, 32'h0000_2000, 0, 32'h0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 32'h0, 0, 32'h0, 0, 1);
        idle(6);
        check("t2_drain_cycles", 64'(obs_drain - base_d), 64'(5));
        check("t2_flush_cycles", 64'(obs_flush - base_f), 64'(2));
        check("t2_no_timeout", 64'(drain_timeout_out), 64'(0));

        // Branch committed together with its own redirect: exactly one update.
        base_b = obs_bp;
        cyc(1, 1, 32'h0000_3000, 1, 32'h0000_0408, 1, 0);
        idle(5);
        check("t3_bp_updates", 64'(obs_bp - base_b), 64'(1));
        check("t3_bp_index", 64'(obs_last_idx), 64'h02);
        check("t3_bp_taken", 64'(obs_last_tk), 64'(1));

        // rdy_in low across the redirect cycle: pulse replayed once.
        base_r = obs_redir;
        cyc(1, 1, 32'h0000_4000, 0, 32'h0, 0, 0);
        cyc(1, 0, 32'h0, 0, 32'h0, 0, 0);
        cyc(1, 0, 32'h0, 0, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 32'h0, 0, 32'h0, 0, 0);
        idle(4);
        check("t4_redirect_pulses", 64'(obs_redir - base_r), 64'(1));
        check("t4_fetch_pc", 64'(fetch_pc_out), 64'h4000);

        // Asynchronous reset in the middle of the flush.
        cyc(1, 1, 32'h0000_5000, 0, 32'h0, 0, 0);
        cyc(1, 0, 32'h0, 0, 32'h0, 0, 0);
        @(negedge clk_in);
        #1;
        check("t5_flush_before_rst", 64'(flush_out), 64'(1));
        rst_in = 0;
        #1;
        check("t5_rst_flush", 64'(flush_out), 64'(0));
        check("t5_rst_stall", 64'(commit_stall_out), 64'(0));
        check("t5_rst_fetch_pc", 64'(fetch_pc_out), 64'(0));
        check("t5_rst_redirect", 64'(fetch_redirect_out), 64'(0));
        model_reset();
        @(negedge clk_in);
        rst_in = 1;
        base_r = obs_redir;
        idle(6);
        check("t5_no_redirect", 64'(obs_redir - base_r), 64'(0));

        rand_cycles(1200, 0);
        pend_left = 0;
        idle(12);

        // Pending held 70 cycles: timeout raised, sticky, sequence still completes.
        base_r = obs_redir;
        cyc(1, 1, 32'h0000_6000, 0, 32'h0, 0, 1);
        for (int i = 0; i < 69; i++) cyc(1, 0, 32'h0, 0, 32'h0, 0, 1);
        idle(8);
        check("t6_timeout_sticky", 64'(drain_timeout_out), 64'(1));
        check("t6_redirect_pulses", 64'(obs_redir - base_r), 64'(1));
        check("t6_fetch_pc", 64'(fetch_pc_out), 64'h6000);

        rand_cycles(1500, 1);
        pend_left = 0;
        for (int i = 0; i < 200 && m_busy; i++) idle(1);
        idle(4);
        check("bp_total", 64'(obs_bp), 64'(exp_bp_total));
`ifdef FLUSH_STATS_EN
        check("stat_flush_count", 64'(flush_count_out), 64'(m_seq));
        check("stat_drain_cycles", 64'(drain_cycles_out), 64'(m_dcyc));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
